// File: rtl/conv_relu_pool_if.sv
// Handshake/data bundle between a psum producer and conv_relu_pool.
// The producer owns r_en/output_conv/bias/clear; the pooler owns the results.
interface conv_relu_pool_if #(
    parameter int CH   = 32,
    parameter int COLS = 4,
    parameter int DW   = 32
);
    logic                          r_en;
    logic [CH*COLS*DW-1:0]         output_conv;
    logic [CH*DW-1:0]              bias;
    logic                          clear;
    logic                          pool_valid;
    logic [CH*(COLS/2)*DW-1:0]     pool_data;
    logic [3:0]                    row_cnt;
    logic                          tile_done;

    modport master (
        output r_en, output_conv, bias, clear,
        input  pool_valid, pool_data, row_cnt, tile_done
    );

    modport slave (
        input  r_en, output_conv, bias, clear,
        output pool_valid, pool_data, row_cnt, tile_done
    );
endinterface

// File: rtl/conv_relu_pool.sv
// Bias add with saturation, ReLU, then 2x2 max-pool over row pairs of a psum tile.
// Even rows are parked in a hold register; the odd row completes the pooling window.
module conv_relu_pool #(
    parameter int CH   = 32,
    parameter int COLS = 4,
    parameter int ROWS = 10,
    parameter int DW   = 32
) (
    input logic             clk,
    input logic             rst_n,
    conv_relu_pool_if.slave bus
);
    localparam int HALF = COLS / 2;
    localparam int ROW_W = CH * COLS * DW;
    localparam int POOL_W = CH * HALF * DW;
    localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);

    typedef enum logic {
        EVEN,
        ODD
    } state_t;

    state_t state;
    state_t next_state;

    logic [ROW_W-1:0]  relu_row;
    logic [ROW_W-1:0]  hold_row;
    logic [POOL_W-1:0] pooled;
    logic [POOL_W-1:0] pool_data_q;
    logic              pool_valid_q;
    logic              tile_done_q;
    logic [3:0]        row_cnt_q;
    logic              load_hold;
    logic              load_pool;
    logic              last_row;

    // Sign-extended add cannot overflow DW+1 bits; saturate back to DW, then clip negatives.
    function automatic logic [DW-1:0] bias_relu(input logic [DW-1:0] x, input logic [DW-1:0] b);
        logic [DW:0]   sum;
        logic [DW-1:0] y;
        sum = {x[DW-1], x} + {b[DW-1], b};
        if (sum[DW] != sum[DW-1]) begin
            y = sum[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end else begin
            y = sum[DW-1:0];
        end
        return y[DW-1] ? '0 : y;
    endfunction

    // Post-ReLU values are never negative, so an unsigned compare is exact.
    function automatic logic [DW-1:0] max_u(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return (a > b) ? a : b;
    endfunction

    always_comb begin
        relu_row = '0;
        for (int c = 0; c < CH; c++) begin
            for (int k = 0; k < COLS; k++) begin
                relu_row[(c*COLS+k)*DW +: DW] =
                    bias_relu(bus.output_conv[(c*COLS+k)*DW +: DW], bus.bias[c*DW +: DW]);
            end
        end
    end

    always_comb begin
        pooled = '0;
        for (int c = 0; c < CH; c++) begin
            for (int j = 0; j < HALF; j++) begin
                pooled[(c*HALF+j)*DW +: DW] = max_u(
                    max_u(hold_row[(c*COLS+2*j)*DW +: DW], hold_row[(c*COLS+2*j+1)*DW +: DW]),
                    max_u(relu_row[(c*COLS+2*j)*DW +: DW], relu_row[(c*COLS+2*j+1)*DW +: DW]));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EVEN;
        end else begin
            state <= next_state;
        end
    end

    // clear outranks r_en, so a coincident beat is dropped rather than stored or pooled.
    always_comb begin
        next_state = state;
        load_hold  = 1'b0;
        load_pool  = 1'b0;
        if (bus.clear) begin
            next_state = EVEN;
        end else if (bus.r_en) begin
            case (state)
                EVEN: begin
                    next_state = ODD;
                    load_hold  = 1'b1;
                end
                ODD: begin
                    next_state = EVEN;
                    load_pool  = 1'b1;
                end
                default: next_state = EVEN;
            endcase
        end
    end

    assign last_row = load_pool && (row_cnt_q == LAST_ROW);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_row     <= '0;
            pool_data_q  <= '0;
            pool_valid_q <= 1'b0;
            tile_done_q  <= 1'b0;
            row_cnt_q    <= '0;
        end else begin
            pool_valid_q <= load_pool;
            tile_done_q  <= last_row;
            if (bus.clear) begin
                hold_row  <= '0;
                row_cnt_q <= '0;
            end else begin
                if (load_hold) begin
                    hold_row <= relu_row;
                end
                if (load_pool) begin
                    pool_data_q <= pooled;
                end
                if (load_hold || load_pool) begin
                    row_cnt_q <= last_row ? 4'd0 : row_cnt_q + 4'd1;
                end
            end
        end
    end

    assign bus.pool_valid = pool_valid_q;
    assign bus.pool_data  = pool_data_q;
    assign bus.tile_done  = tile_done_q;
    assign bus.row_cnt    = row_cnt_q;
endmodule

// File: tb/tb_conv_relu_pool.sv
// Directed and randomized checks of conv_relu_pool against a row-pair reference model.
module tb_conv_relu_pool;
    localparam int CH   = 32;
    localparam int COLS = 4;
    localparam int ROWS = 10;
    localparam int DW   = 32;
    localparam int HALF = COLS / 2;

    logic clk;
    logic rst_n;
    int   error_count;
    int   check_count;
    int   pulse_count;

    longint held     [CH][COLS];
    longint exp_pool [CH][HALF];
    bit     have_held;
    int     exp_row;
    bit     exp_valid;
    bit     exp_done;

    conv_relu_pool_if #(.CH(CH), .COLS(COLS), .DW(DW)) bus ();

    conv_relu_pool #(.CH(CH), .COLS(COLS), .ROWS(ROWS), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        check_count++;
        if (observed != expected) begin
            error_count++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic longint laneOf(input int c, input int j);
        return longint'(bus.pool_data[(c*HALF+j)*DW +: DW]);
    endfunction

    // Saturating add followed by ReLU collapses to a clamp into [0, 2^31-1].
    function automatic longint reluRef(input longint x, input longint b);
        longint s;
        s = x + b;
        if (s < 0) return 0;
        if (s > 64'sd2147483647) return 64'sd2147483647;
        return s;
    endfunction

    task automatic modelReset();
        have_held = 0;
        exp_row   = 0;
        exp_valid = 0;
        exp_done  = 0;
        for (int c = 0; c < CH; c++)
            for (int j = 0; j < HALF; j++)
                exp_pool[c][j] = 0;
    endtask

    task automatic modelStep(input bit en, input bit clr);
        longint cur [CH][COLS];
        longint m;
        exp_valid = 0;
        exp_done  = 0;
        if (clr) begin
            have_held = 0;
            exp_row   = 0;
        end else if (en) begin
            for (int c = 0; c < CH; c++)
                for (int k = 0; k < COLS; k++)
                    cur[c][k] = reluRef(longint'($signed(bus.output_conv[(c*COLS+k)*DW +: DW])),
                                        longint'($signed(bus.bias[c*DW +: DW])));
            if (!have_held) begin
                held      = cur;
                have_held = 1;
                exp_row   = exp_row + 1;
            end else begin
                for (int c = 0; c < CH; c++) begin
                    for (int j = 0; j < HALF; j++) begin
                        m = held[c][2*j];
                        if (held[c][2*j+1] > m) m = held[c][2*j+1];
                        if (cur[c][2*j] > m) m = cur[c][2*j];
                        if (cur[c][2*j+1] > m) m = cur[c][2*j+1];
                        exp_pool[c][j] = m;
                    end
                end
                exp_valid = 1;
                exp_done  = (exp_row == ROWS - 1);
                exp_row   = (exp_row + 1) % ROWS;
                have_held = 0;
            end
        end
    endtask

    task automatic checkState();
        checkOutput("pool_valid", longint'(bus.pool_valid), longint'(exp_valid));
        checkOutput("tile_done", longint'(bus.tile_done), longint'(exp_done));
        checkOutput("row_cnt", longint'(bus.row_cnt), longint'(exp_row));
        for (int c = 0; c < CH; c++)
            for (int j = 0; j < HALF; j++)
                checkOutput($sformatf("pool_c%0d_j%0d", c, j), laneOf(c, j), exp_pool[c][j]);
    endtask

    task automatic applyStimulus(input bit en, input bit clr);
        bus.r_en  = en;
        bus.clear = clr;
        @(posedge clk);
        #1;
        modelStep(en, clr);
        checkState();
        if (bus.pool_valid) pulse_count++;
        bus.r_en  = 1'b0;
        bus.clear = 1'b0;
    endtask

    task automatic setRowConst(input int v);
        for (int i = 0; i < CH*COLS; i++) bus.output_conv[i*DW +: DW] = 32'(v);
    endtask

    task automatic setBiasConst(input int b);
        for (int c = 0; c < CH; c++) bus.bias[c*DW +: DW] = 32'(b);
    endtask

    task automatic setRowCols(input int a0, input int a1, input int a2, input int a3);
        for (int c = 0; c < CH; c++) begin
            bus.output_conv[(c*COLS+0)*DW +: DW] = 32'(a0);
            bus.output_conv[(c*COLS+1)*DW +: DW] = 32'(a1);
            bus.output_conv[(c*COLS+2)*DW +: DW] = 32'(a2);
            bus.output_conv[(c*COLS+3)*DW +: DW] = 32'(a3);
        end
    endtask

    function automatic logic [31:0] randWord();
        case ($urandom_range(0, 3))
            0: return 32'($urandom);
            1: return 32'(int'($urandom_range(0, 2000)) - 1000);
            2: return 32'($urandom_range(2147483000, 2147483647));
            default: return 32'($urandom_range(0, 500));
        endcase
    endfunction

    task automatic randomizeRow();
        for (int i = 0; i < CH*COLS; i++) bus.output_conv[i*DW +: DW] = randWord();
    endtask

    task automatic randomizeBias();
        for (int c = 0; c < CH; c++) bus.bias[c*DW +: DW] = randWord();
    endtask

    initial begin
        error_count = 0;
        check_count = 0;
        pulse_count = 0;
        rst_n = 1'b1;
        bus.r_en = 1'b0;
        bus.clear = 1'b0;
        bus.output_conv = '0;
        bus.bias = '0;
        modelReset();

        #1 rst_n = 1'b0;
        #1 checkState();
        @(negedge clk);
        rst_n = 1'b1;

        // Ten constant rows spaced six cycles apart: pooled value equals the odd row index.
        setBiasConst(0);
        pulse_count = 0;
        for (int r = 0; r < ROWS; r++) begin
            setRowConst(r);
            applyStimulus(1'b1, 1'b0);
            if (r % 2 == 1) begin
                checkOutput("req029_lane0", laneOf(0, 0), r);
                checkOutput("req029_lane_last", laneOf(CH-1, HALF-1), r);
                checkOutput("req029_done", longint'(bus.tile_done), (r == ROWS-1) ? 1 : 0);
            end
            repeat (5) applyStimulus(1'b0, 1'b0);
        end
        checkOutput("req029_pulses", pulse_count, 5);

        setBiasConst(-5);
        setRowConst(3);
        applyStimulus(1'b1, 1'b0);
        setRowConst(10);
        applyStimulus(1'b1, 1'b0);
        checkOutput("req030_val", laneOf(3, 1), 5);

        setBiasConst(32'h100);
        setRowConst(32'h7FFFFFF0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("req031_sat", laneOf(5, 0), 64'h7FFFFFFF);
        setBiasConst(50);
        setRowConst(-100);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("req031_neg", laneOf(5, 0), 0);

        setBiasConst(0);
        setRowCols(1, 9, 2, 4);
        applyStimulus(1'b1, 1'b0);
        setRowCols(3, 0, 8, 7);
        applyStimulus(1'b1, 1'b0);
        checkOutput("req032_j0", laneOf(7, 0), 9);
        checkOutput("req032_j1", laneOf(7, 1), 8);
        applyStimulus(1'b0, 1'b0);
        checkOutput("hold_data", laneOf(7, 1), 8);

        // Clear collides with row 3; only rows 0/1 before and after the clear pool.
        applyStimulus(1'b0, 1'b1);
        pulse_count = 0;
        for (int r = 0; r < 3; r++) begin
            setRowConst(20 + r);
            applyStimulus(1'b1, 1'b0);
        end
        setRowConst(99);
        applyStimulus(1'b1, 1'b1);
        checkOutput("req033_clr_cnt", longint'(bus.row_cnt), 0);
        setRowConst(4);
        applyStimulus(1'b1, 1'b0);
        setRowConst(6);
        applyStimulus(1'b1, 1'b0);
        checkOutput("req033_val", laneOf(0, 0), 6);
        repeat (2) applyStimulus(1'b0, 1'b0);
        checkOutput("req033_pulses", pulse_count, 2);
        checkOutput("req033_row_cnt", longint'(bus.row_cnt), 2);

        // Asynchronous reset after a held row: outputs drop without a clock edge.
        applyStimulus(1'b0, 1'b1);
        setRowConst(50);
        applyStimulus(1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1 modelReset();
        checkState();
        @(negedge clk);
        rst_n = 1'b1;
        pulse_count = 0;
        setRowConst(7);
        applyStimulus(1'b1, 1'b0);
        setRowConst(3);
        applyStimulus(1'b1, 1'b0);
        checkOutput("req034_val", laneOf(2, 1), 7);
        repeat (2) applyStimulus(1'b0, 1'b0);
        checkOutput("req034_pulses", pulse_count, 1);

        // Random traffic including back-to-back rows; bias only changes at tile boundaries.
        applyStimulus(1'b0, 1'b1);
        randomizeBias();
        for (int i = 0; i < 600; i++) begin
            if (exp_row == 0 && !have_held && $urandom_range(0, 1) == 1) randomizeBias();
            randomizeRow();
            applyStimulus(($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0,
                          ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end
endmodule
